gift_sprite_engine: RTL and testbench

- Parametrised multi-object renderer for the falling-object game. Replaces the single hard-wired box of the first demo.
- Holds up to NUM_OBJ rectangles. On each frame tick it erases, moves down and redraws every active object, one pixel per clock.
- Sits between game logic (spawn handshake) and the VGA adapter (VGA_X/VGA_Y/VGA_COLOR/plot).

---
 rtl/gift_vga_pkg.sv | 17 +
 rtl/gift_sprite_engine_if.sv | 32 +++
 rtl/gift_sprite_engine_rect_scan.sv | 38 +++
 rtl/gift_sprite_engine.sv | 193 +++++++++++++++++++
 tb/tb_gift_sprite_engine.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gift_vga_pkg.sv
// Shared types and helpers for the falling-object sprite engine.
package gift_vga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEL, ST_ERASE, ST_MOVE, ST_DRAW, ST_NEXT, ST_DONE
  } state_e;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Worst-case cycles for one frame update over n_obj slots of w x h pixels.
  function automatic int frame_cycles(input int n_obj, input int w, input int h);
    return n_obj * (2 * w * h + 4) + 2;
  endfunction

endpackage

// File: rtl/gift_sprite_engine_if.sv
// Spawn handshake from game logic and registered pixel stream to the VGA adapter.
interface gift_sprite_engine_if #(
  parameter int NX      = 8,
  parameter int NY      = 7,
  parameter int COLOR_W = 9,
  parameter int NUM_OBJ = 4
);
  localparam int CW = $clog2(NUM_OBJ + 1);

  logic               spawn_valid;
  logic               spawn_ready;
  logic [NX-1:0]      spawn_x;
  logic [COLOR_W-1:0] spawn_color;
  logic [2:0]         speed;
  logic [NX-1:0]      VGA_X;
  logic [NY-1:0]      VGA_Y;
  logic [COLOR_W-1:0] VGA_COLOR;
  logic               plot;
  logic               frame_done;
  logic               missed;
  logic [CW-1:0]      active_count;

  modport master (
    output spawn_valid, spawn_x, spawn_color, speed,
    input  spawn_ready, VGA_X, VGA_Y, VGA_COLOR, plot, frame_done, missed, active_count
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_color, speed,
    output spawn_ready, VGA_X, VGA_Y, VGA_COLOR, plot, frame_done, missed, active_count
  );
endinterface

// File: rtl/gift_sprite_engine_rect_scan.sv
// Row-major W x H raster stepper shared by the erase and draw passes.
module rect_scan import gift_vga_pkg::*; #(
  parameter int W  = 8,
  parameter int H  = 4,
  parameter int XW = cnt_w(W),
  parameter int YW = cnt_w(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic [XW-1:0] o_px,
  output logic [YW-1:0] o_py,
  output logic          o_last
);
  localparam logic [XW-1:0] X_LAST = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

  logic [XW-1:0] r_px;
  logic [YW-1:0] r_py;

  // Held at the origin while disabled so every pass starts at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_px <= '0;
      r_py <= '0;
    end else if (!i_en || r_px == X_LAST) begin
      r_px <= '0;
      if (!i_en || r_py == Y_LAST) r_py <= '0;
      else                         r_py <= r_py + YW'(1);
    end else begin
      r_px <= r_px + XW'(1);
    end
  end

  assign o_px   = r_px;
  assign o_py   = r_py;
  assign o_last = i_en && (r_px == X_LAST) && (r_py == Y_LAST);
endmodule

// File: rtl/gift_sprite_engine.sv
// Multi-object falling-sprite renderer: per tick erase, move and redraw each slot.
// Optional speed ramp with misses is enabled by defining GIFT_SPEED_RAMP_EN.
module gift_sprite_engine import gift_vga_pkg::*; #(
  parameter int X_RES    = 160,
  parameter int Y_RES    = 120,
  parameter int NX       = 8,
  parameter int NY       = 7,
  parameter int COLOR_W  = 9,
  parameter int NUM_OBJ  = 4,
  parameter int OBJ_W    = 8,
  parameter int OBJ_H    = 4,
  parameter int TICK_DIV = 833333,
  parameter int BG_COLOR = 0
) (
  input logic CLOCK_50,
  input logic Reset,
  gift_sprite_engine_if.slave bus
);
  localparam int XW  = cnt_w(OBJ_W);
  localparam int YW  = cnt_w(OBJ_H);
  localparam int IW  = cnt_w(NUM_OBJ);
  localparam int TW  = cnt_w(TICK_DIV);
  localparam int CW  = $clog2(NUM_OBJ + 1);
  localparam int NYE = NY + 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [NX-1:0]  X_MAX     = NX'(X_RES - OBJ_W);
  localparam logic [NYE-1:0] Y_MAX     = NYE'(Y_RES - OBJ_H);

  state_e              r_state, w_state_nxt;
  logic [TW-1:0]       r_tick_cnt;
  logic                r_tick_pending, w_wrap;
  logic [NUM_OBJ-1:0]  r_act, r_drawn;
  logic [NX-1:0]       r_x   [NUM_OBJ];
  logic [NY-1:0]       r_y   [NUM_OBJ];
  logic [COLOR_W-1:0]  r_col [NUM_OBJ];
  logic [IW-1:0]       r_idx, w_free_idx;
  logic                w_has_free, w_spawn, w_scan_en, w_last, w_off;
  logic [XW-1:0]       w_px;
  logic [YW-1:0]       w_py;
  logic [2:0]          w_speed;
  logic [NYE-1:0]      w_y_new;
  logic [CW-1:0]       w_count;
  logic [NX-1:0]       r_vga_x;
  logic [NY-1:0]       r_vga_y;
  logic [COLOR_W-1:0]  r_vga_c;
  logic                r_plot;

  assign w_wrap = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_tick_cnt     <= '0;
      r_tick_pending <= 1'b0;
    end else begin
      r_tick_cnt <= w_wrap ? '0 : r_tick_cnt + TW'(1);
      if (w_wrap)                                    r_tick_pending <= 1'b1;
      else if (r_state == ST_IDLE && r_tick_pending) r_tick_pending <= 1'b0;
    end
  end

  always_comb begin
    w_free_idx = '0;
    w_has_free = 1'b0;
    w_count    = '0;
    for (int k = NUM_OBJ - 1; k >= 0; k--) begin
      if (!r_act[k]) begin
        w_free_idx = IW'(k);
        w_has_free = 1'b1;
      end
      w_count = w_count + CW'(r_act[k]);
    end
  end

  assign bus.spawn_ready  = !Reset && (r_state == ST_IDLE) && w_has_free;
  assign w_spawn          = bus.spawn_valid && bus.spawn_ready;
  assign bus.active_count = w_count;

`ifdef GIFT_SPEED_RAMP_EN
  logic [2:0] r_miss_cnt, r_bonus;
  logic [3:0] w_sum;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_miss_cnt <= '0;
      r_bonus    <= '0;
    end else if (bus.missed) begin
      r_miss_cnt <= r_miss_cnt + 3'd1;
      if (r_miss_cnt == 3'd7 && r_bonus != 3'd7) r_bonus <= r_bonus + 3'd1;
    end
  end

  assign w_sum   = {1'b0, bus.speed} + {1'b0, r_bonus};
  assign w_speed = w_sum[3] ? 3'd7 : w_sum[2:0];
`else
  assign w_speed = bus.speed;
`endif

  // A slot that has never been drawn gets a zero move so it first appears at y = 0.
  assign w_y_new = {1'b0, r_y[r_idx]} + (r_drawn[r_idx] ? NYE'(w_speed) : '0);
  assign w_off   = (w_y_new > Y_MAX);

  assign bus.missed     = (r_state == ST_MOVE) && w_off;
  assign bus.frame_done = (r_state == ST_DONE);
  assign w_scan_en      = (r_state == ST_ERASE) || (r_state == ST_DRAW);

  rect_scan #(.W(OBJ_W), .H(OBJ_H), .XW(XW), .YW(YW)) u_scan (
    .clk    (CLOCK_50),
    .rst    (Reset),
    .i_en   (w_scan_en),
    .o_px   (w_px),
    .o_py   (w_py),
    .o_last (w_last)
  );

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (r_tick_pending) w_state_nxt = ST_SEL;
      ST_SEL: begin
        if (!r_act[r_idx])        w_state_nxt = ST_NEXT;
        else if (r_drawn[r_idx])  w_state_nxt = ST_ERASE;
        else                      w_state_nxt = ST_MOVE;
      end
      ST_ERASE: if (w_last) w_state_nxt = ST_MOVE;
      ST_MOVE:  w_state_nxt = w_off ? ST_NEXT : ST_DRAW;
      ST_DRAW:  if (w_last) w_state_nxt = ST_NEXT;
      ST_NEXT:  w_state_nxt = (r_idx == IW'(NUM_OBJ - 1)) ? ST_DONE : ST_SEL;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_act   <= '0;
      r_drawn <= '0;
      r_idx   <= '0;
      for (int k = 0; k < NUM_OBJ; k++) begin
        r_x[k]   <= '0;
        r_y[k]   <= '0;
        r_col[k] <= '0;
      end
    end else begin
      if (w_spawn) begin
        r_act[w_free_idx]   <= 1'b1;
        r_drawn[w_free_idx] <= 1'b0;
        r_x[w_free_idx]     <= (bus.spawn_x > X_MAX) ? X_MAX : bus.spawn_x;
        r_y[w_free_idx]     <= '0;
        r_col[w_free_idx]   <= bus.spawn_color;
      end
      case (r_state)
        ST_IDLE: r_idx <= '0;
        ST_MOVE: begin
          if (w_off) begin
            r_act[r_idx]   <= 1'b0;
            r_drawn[r_idx] <= 1'b0;
          end else begin
            r_y[r_idx] <= w_y_new[NY-1:0];
          end
        end
        ST_DRAW: if (w_last) r_drawn[r_idx] <= 1'b1;
        ST_NEXT: r_idx <= r_idx + IW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_plot  <= 1'b0;
      r_vga_x <= '0;
      r_vga_y <= '0;
      r_vga_c <= '0;
    end else begin
      r_plot <= w_scan_en;
      if (w_scan_en) begin
        r_vga_x <= r_x[r_idx] + NX'(w_px);
        r_vga_y <= r_y[r_idx] + NY'(w_py);
        r_vga_c <= (r_state == ST_DRAW) ? r_col[r_idx] : COLOR_W'(BG_COLOR);
      end
    end
  end

  assign bus.VGA_X     = r_vga_x;
  assign bus.VGA_Y     = r_vga_y;
  assign bus.VGA_COLOR = r_vga_c;
  assign bus.plot      = r_plot;
endmodule

// File: tb/tb_gift_sprite_engine.sv
// Scoreboard bench for gift_sprite_engine: a behavioural slot model predicts every plotted pixel.
module tb_gift_sprite_engine;
  import gift_vga_pkg::*;

  localparam int TICK   = 400;
  localparam int TICK_F = 50;
  localparam int NOBJ   = 4;
  localparam int OW     = 8;
  localparam int OH     = 4;
  localparam int XMAX   = 160 - OW;
  localparam int YMAX   = 120 - OH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  gift_sprite_engine_if #(.NX(8), .NY(7), .COLOR_W(9), .NUM_OBJ(NOBJ)) bus ();
  gift_sprite_engine_if #(.NX(8), .NY(7), .COLOR_W(9), .NUM_OBJ(NOBJ)) bus_f ();

  gift_sprite_engine #(.TICK_DIV(TICK)) dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .bus      (bus)
  );

  gift_sprite_engine #(.TICK_DIV(TICK_F)) dut_f (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .bus      (bus_f)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  bit   m_act   [NOBJ];
  bit   m_drawn [NOBJ];
  int   m_x     [NOBJ];
  int   m_y     [NOBJ];
  int   m_col   [NOBJ];
  int   exp_miss = 0;
  logic [23:0] sb[$];

  int     extra = 0, miss_seen = 0, fd_seen = 0, max_x = 0;
  int     fd_f = 0, plots_f = 0, miss_f = 0;
  longint cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.plot) begin
      if (int'(bus.VGA_X) > max_x) max_x = int'(bus.VGA_X);
      if (sb.size() == 0) extra++;
      else check("pixel", {bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR}, sb.pop_front());
    end
    if (bus.frame_done) fd_seen++;
    if (bus.missed)     miss_seen++;
    if (bus_f.plot)       plots_f++;
    if (bus_f.frame_done) fd_f++;
    if (bus_f.missed)     miss_f++;
  end

  task automatic push_rect(input int x, input int y, input int c);
    for (int r = 0; r < OH; r++)
      for (int k = 0; k < OW; k++)
        sb.push_back({8'(x + k), 7'(y + r), 9'(c)});
  endtask

  task automatic model_frame(input int spd);
    for (int i = 0; i < NOBJ; i++) begin
      if (m_act[i]) begin
        int yn;
        if (m_drawn[i]) push_rect(m_x[i], m_y[i], 0);
        yn = m_y[i] + (m_drawn[i] ? spd : 0);
        if (yn > YMAX) begin
          m_act[i]   = 1'b0;
          m_drawn[i] = 1'b0;
          exp_miss++;
        end else begin
          m_y[i] = yn;
          push_rect(m_x[i], m_y[i], m_col[i]);
          m_drawn[i] = 1'b1;
        end
      end
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NOBJ; i++) n += int'(m_act[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NOBJ; i++) begin
      m_act[i] = 1'b0; m_drawn[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_col[i] = 0;
    end
  endtask

  task automatic spawn(input int x, input int c);
    int n = 0;
    int s = -1;
    while (!bus.spawn_ready && n < 2 * TICK) begin
      @(negedge clk);
      n++;
    end
    check("spawn_ready_wait", n < 2 * TICK, 1);
    bus.spawn_x     = 8'(x);
    bus.spawn_color = 9'(c);
    bus.spawn_valid = 1'b1;
    @(posedge clk);
    #1 bus.spawn_valid = 1'b0;
    for (int i = NOBJ - 1; i >= 0; i--) if (!m_act[i]) s = i;
    if (s >= 0) begin
      m_act[s]   = 1'b1;
      m_drawn[s] = 1'b0;
      m_x[s]     = (x > XMAX) ? XMAX : x;
      m_y[s]     = 0;
      m_col[s]   = c;
    end
  endtask

  task automatic run_frame(input int spd);
    int start;
    int n = 0;
    start = fd_seen;
    extra = 0;
    model_frame(spd);
    while (fd_seen == start && n < 3 * TICK) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("frame_timeout", n < 3 * TICK, 1);
    check("sb_left", sb.size(), 0);
    check("extra_plots", extra, 0);
    check("missed", miss_seen, exp_miss);
    check("active_count", bus.active_count, model_count());
    sb.delete();
  endtask

  task automatic spawn_f(input int x, input int c);
    int n = 0;
    while (!bus_f.spawn_ready && n < 2 * TICK) begin
      @(negedge clk);
      n++;
    end
    check("fast_spawn_wait", n < 2 * TICK, 1);
    bus_f.spawn_x     = 8'(x);
    bus_f.spawn_color = 9'(c);
    bus_f.spawn_valid = 1'b1;
    @(posedge clk);
    #1 bus_f.spawn_valid = 1'b0;
  endtask

  initial begin
    int g;
    int n;
    int s_fd, s_pl;
    longint s_cyc, d_cyc;

    bus.spawn_valid = 1'b0; bus.spawn_x = '0; bus.spawn_color = '0; bus.speed = '0;
    bus_f.spawn_valid = 1'b0; bus_f.spawn_x = '0; bus_f.spawn_color = '0; bus_f.speed = '0;
    model_clear();

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_plot", bus.plot, 0);
    check("rst_ready", bus.spawn_ready, 0);
    check("rst_active", bus.active_count, 0);
    check("rst_frame_done", bus.frame_done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", bus.spawn_ready, 1);

    // First object: first frame draws it at y 0..3, second erases and redraws at y 2..5.
    bus.speed = 3'd2;
    spawn(10, 'h1C0);
    check("active_after_spawn", bus.active_count, 1);
    run_frame(2);
    check("frame_count_1", fd_seen, 1);
    run_frame(2);
    check("frame_count_2", fd_seen, 2);

    spawn(200, 'h03F);
    run_frame(2);
    check("clamp_max_x", max_x, 159);

    spawn(40, 'h111);
    spawn(80, 'h0AA);
    check("ready_full", bus.spawn_ready, 0);
    check("active_full", bus.active_count, 4);
    bus.spawn_x = 8'd5;
    bus.spawn_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.spawn_valid = 1'b0;
    check("active_held", bus.active_count, 4);
    run_frame(2);

    // Walk slot 0 down to y = 114, then a speed-3 move pushes it past the bottom.
    g = 0;
    while (m_act[0] && m_y[0] < 114 && g < 80) begin
      run_frame(2);
      g++;
    end
    bus.speed = 3'd3;
    run_frame(3);
    check("ready_after_miss", bus.spawn_ready, 1);

    // Slot 1 must stay at y = 116 (last legal row) before missing one frame later.
    bus.speed = 3'd1;
    g = 0;
    while (m_act[1] && g < 10) begin
      run_frame(1);
      g++;
    end

    // Reset in the middle of a draw pass.
    model_frame(1);
    n = 0;
    while (!(bus.plot && bus.VGA_COLOR != 0) && n < 3 * TICK) begin
      @(negedge clk);
      n++;
    end
    check("draw_seen", n < 3 * TICK, 1);
    #1 rst = 1'b1;
    sb.delete();
    model_clear();
    #1;
    check("rst_mid_plot", bus.plot, 0);
    check("rst_mid_active", bus.active_count, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_miss = miss_seen;
    extra = 0;
    repeat (2 * TICK + 10) @(posedge clk);
    #1;
    check("no_plot_after_rst", extra, 0);
    check("active_after_rst", bus.active_count, 0);
    spawn(0, 'h155);
    run_frame(1);

    // Short tick period: frames run back-to-back with excess ticks dropped.
    for (int k = 0; k < NOBJ; k++) spawn_f(k * 30, 'h100 + k);
    check("fast_active", bus_f.active_count, 4);
    s_fd = fd_f;
    n = 0;
    while (fd_f < s_fd + 2 && n < 4 * TICK) begin
      @(posedge clk);
      n++;
    end
    s_fd = fd_f; s_pl = plots_f; s_cyc = cyc;
    n = 0;
    while (fd_f < s_fd + 10 && n < 12 * TICK) begin
      @(posedge clk);
      n++;
    end
    d_cyc = cyc - s_cyc;
    check("fast_timeout", n < 12 * TICK, 1);
    check("fast_plots", plots_f - s_pl, 10 * NOBJ * 2 * OW * OH);
    check("fast_cadence", (d_cyc >= 10 * NOBJ * 2 * OW * OH) &&
                          (d_cyc <= 10 * frame_cycles(NOBJ, OW, OH)), 1);
    check("fast_no_miss", miss_f, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
